// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin, bounded-burst arbiter sharing one FIFO write port among NREQ requesters
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 4
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    busy
);
    localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   own_q, own_d, rr_q, rr_d, sel, idx;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d, found, rel, go, drop;

    // first requester at or after rr_q, wrapping modulo NREQ
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign winc  = (state_q == GRANT) & req[own_q] & ~wfull;
    assign wdata = (state_q == GRANT) ? req_data[int'(own_q)*DSIZE +: DSIZE] : '0;
    assign ack   = gnt_q & {NREQ{winc}};
    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign rel   = (winc & (req_last[own_q] | (cnt_q == CNTW'(BURST-1)))) | ~req[own_q];

    always_comb begin
        go      = (state_q == IDLE) & found;
        drop    = (state_q == GRANT) & rel;
        state_d = go ? GRANT : drop ? IDLE : state_q;
        gnt_d   = go ? (NREQ'(1) << sel) : drop ? '0 : gnt_q;
        own_d   = go ? sel : own_q;
        rr_d    = drop ? ((own_q == IW'(NREQ-1)) ? '0 : own_q + 1'b1) : rr_q;
        cnt_d   = (go | drop) ? '0 : winc ? cnt_q + 1'b1 : cnt_q;
        busy_d  = go ? 1'b1 : drop ? 1'b0 : busy_q;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: random requesters checked cycle by cycle against a behavioural arbitration model
module tb_fifo_wr_arb;
    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
    localparam int CNTW  = 4;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req, req_last, gnt, ack;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  wfull, winc, busy;
    logic [DSIZE-1:0]      wdata;

    fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST), .CNTW(CNTW)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .req_last(req_last),
        .wfull(wfull), .winc(winc), .wdata(wdata), .gnt(gnt), .ack(ack), .busy(busy)
    );

    always #5 wclk = ~wclk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // requester stimulus state and reference model
    logic [NREQ-1:0]  pres, lst, acked;
    logic [DSIZE-1:0] dat [NREQ];
    int owner = -1, rr = 0, words = 0;
    logic             e_winc, e_busy;
    logic [NREQ-1:0]  e_gnt, e_ack;
    logic [DSIZE-1:0] e_wdata;
    logic [NREQ-1:0]  order [$];
    int               bursts [$];
    logic [NREQ-1:0]  prev_g = '0;
    int               wc = 0;

    task automatic drive(input int mode);
        for (int i = 0; i < NREQ; i++) begin
            if (pres[i] && !acked[i]) begin
                if (mode == 0 && $urandom_range(0, 15) == 0) pres[i] = 1'b0;
            end else begin
                pres[i] = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                dat[i]  = DSIZE'($urandom);
                lst[i]  = (mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
            end
            req_data[i*DSIZE +: DSIZE] = dat[i];
        end
        req      = pres;
        req_last = lst;
        wfull    = (mode == 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
    endtask

    task automatic cycle(input int mode);
        int nxt;
        drive(mode);
        e_winc  = (owner >= 0) && req[owner] && !wfull;
        e_gnt   = (owner >= 0) ? NREQ'(1) << owner : '0;
        e_wdata = (owner >= 0) ? dat[owner] : '0;
        e_ack   = e_winc ? e_gnt : '0;
        e_busy  = (owner >= 0);
        @(negedge wclk);
        check("gnt", gnt, e_gnt);
        check("winc", winc, e_winc);
        check("wdata", wdata, e_wdata);
        check("ack", ack, e_ack);
        check("busy", busy, e_busy);
        check("winc_while_full", winc & wfull, 0);
        if (mode == 1) begin
            if (winc) wc++;
            if (gnt != '0 && gnt != prev_g) order.push_back(gnt);
            if (gnt == '0 && prev_g != '0) begin
                bursts.push_back(wc);
                wc = 0;
            end
            prev_g = gnt;
        end
        @(posedge wclk);
        if (owner < 0) begin
            nxt = -1;
            for (int k = 0; k < NREQ; k++)
                if (nxt < 0 && req[(rr + k) % NREQ]) nxt = (rr + k) % NREQ;
            owner = nxt;
            words = 0;
        end else if ((e_winc && (lst[owner] || words + 1 == BURST)) || !req[owner]) begin
            rr    = (owner + 1) % NREQ;
            owner = -1;
            words = 0;
        end else if (e_winc) begin
            words++;
        end
        acked = e_ack;
        #1;
    endtask

    // asynchronous reset asserted mid-cycle, away from any clock edge
    task automatic do_reset();
        #2;
        wrst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_winc", winc, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_wdata", wdata, 0);
        pres  = '0;
        lst   = '0;
        acked = '0;
        req   = '0;
        req_last = '0;
        wfull = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        owner  = -1;
        rr     = 0;
        words  = 0;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        int exp_ord [5] = '{1, 2, 4, 8, 1};
        wrst_n   = 1'b0;
        req      = '0;
        req_last = '0;
        req_data = '0;
        wfull    = 1'b0;
        pres     = '0;
        lst      = '0;
        acked    = '0;
        for (int i = 0; i < NREQ; i++) dat[i] = '0;
        @(posedge wclk);
        #1;
        do_reset();
        repeat (30) cycle(1);
        check("order_len", order.size() >= 5, 1);
        check("burst_cnt", bursts.size() >= 4, 1);
        for (int i = 0; i < 5 && i < order.size(); i++) check($sformatf("order%0d", i), order[i], exp_ord[i]);
        for (int i = 0; i < 4 && i < bursts.size(); i++) check($sformatf("burst%0d", i), bursts[i], BURST);
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            cycle(0);
            if (n == 500 || n == 1000) begin
                for (int t = 0; t < 50 && owner < 0; t++) cycle(0);
                check("midburst_owner", owner >= 0, 1);
                do_reset();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter/sequencer for the asynchronous FIFO.
- Lets NREQ write-domain requesters share the single winc/wdata port.
- Grants bounded bursts, honours the registered wfull flag, and releases early on end-of-packet.
- Sits entirely in the write clock domain, directly in front of the FIFO write-pointer/memory logic.

Parameters:
- NREQ, 4, number of requesters; must be ≥2.
- DSIZE, 8, FIFO data width.
- BURST, 4, maximum words written per grant; range 1..16.
- CNTW, 4, burst counter width; must satisfy 2**CNTW ≥ BURST.

Ports:
- wclk  input  1  write-domain clock; all state updates on posedge.
- wrst_n  input  1  asynchronous active-low reset; clears all state immediately.
- req  input  NREQ  requester i has a word presented.
- req_data  input  NREQ*DSIZE  word of requester i on bits [i*DSIZE +: DSIZE].
- req_last  input  NREQ  presented word is the last of requester i's packet.
- wfull  input  1  FIFO full flag, registered in the wclk domain.
- winc  output  1  write strobe to FIFO; combinational from state and inputs.
- wdata  output  DSIZE  data to FIFO; the owner's req_data, 0 when no owner.
- gnt  output  NREQ  one-hot current owner, registered; all-zero when idle.
- ack  output  NREQ  word of requester i accepted this cycle: gnt[i] & winc.
- busy  output  1  registered; 1 while in GRANT.

Behaviour:
- Reset (async, wrst_n=0):
  - state=IDLE, gnt=0, rr_ptr=0, cnt=0, busy=0.
  - winc=0, wdata=0, ack=0 while reset is held.
  - No write may issue on the first edge after reset release.
- State IDLE:
  - winc=0.
  - If |req, select the first index with req set, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - Next edge: gnt=onehot(sel), cnt=0, state=GRANT, busy=1.
  - If req==0, stay IDLE.
- State GRANT, owner o:
  - winc = req[o] & ~wfull.
  - wdata = req_data[o].
  - On an edge with winc=1, cnt increments.
- Release condition, evaluated each GRANT cycle:
  - (a) winc & req_last[o],
  - (b) winc & (cnt==BURST-1), or
  - (c) ~req[o] (requester withdrew).
- On release:
  - Next edge: state=IDLE, gnt=0, busy=0, cnt=0, rr_ptr=(o+1) mod NREQ.
  - There is exactly one IDLE bubble cycle between grants, so the fixed arbitration latency is 1 cycle from IDLE to grant.
- wfull=1 during GRANT:
  - winc=0, cnt holds, ownership holds. There is no timeout.
  - Release via (c) is still allowed while full.
- Simultaneous req_last and cnt==BURST-1: a single release; no double count.
- BURST=1: every accepted word releases the grant.
- Requests arriving during GRANT are ignored until the next IDLE arbitration.
- req change during GRANT for non-owners has no effect.
- wfull is never written into: winc & wfull must be 0 in every cycle. This is a checked invariant.
- Reset mid-burst: grant is dropped immediately (gnt=0, winc=0). Partial packets are not restarted; packet recovery is the requester's responsibility.
- Requester contract: hold req, req_data and req_last stable until ack.

Test Plan:
- Reset, then req=4'b0001 with req_last asserted on the 3rd word, wfull=0:
  - gnt=0001 one cycle after req.
  - winc high 3 cycles with ack[0] each cycle, then gnt=0, then a one-cycle IDLE bubble.
- req=4'b1111 held with req_last=0, BURST=4:
  - Grants in order 0,1,2,3,0.
  - Each grant writes exactly 4 words; 5 cycles per grant including the bubble.
- Owner 2 granted; wfull=1 for cycles 2-6 of its burst:
  - winc=0 and cnt frozen during the full cycles.
  - Resumes on wfull=0; 4 words total; rr_ptr=3 afterwards.
- Owner 1 drops req after 1 word:
  - Release next edge; rr_ptr=2; a pending req[0] is served only after req[2]/req[3] are checked.
- req_last coincides with the 4th word:
  - Single release; the next owner starts after one bubble; wdata equals req_data of the new owner.
- Assert wrst_n=0 mid-burst (gnt=0100, cnt=2):
  - gnt, winc and busy go 0 without a clock edge.
  - After release with req=0100, arbitration restarts from rr_ptr=0 and grants index 2 with cnt=0.
